// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the handshaked sequential ALU.
// The flag packing helper keeps the flag bit order defined in one place.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_SLT  = 4'h6,
        OP_SLTU = 4'h7,
        OP_SLL  = 4'h8,
        OP_SRL  = 4'h9,
        OP_SRA  = 4'hA,
        OP_MUL  = 4'hB
    } op_e;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_e;

    localparam int FLG_ZERO    = 0;
    localparam int FLG_EQUAL   = 1;
    localparam int FLG_OVF     = 2;
    localparam int FLG_CARRY   = 3;
    localparam int FLG_ILLEGAL = 4;
    localparam int FLAG_W      = 5;

    function automatic logic [FLAG_W-1:0] packFlags(input logic illegal, input logic carry,
                                                    input logic ovf, input logic equal,
                                                    input logic zero);
        logic [FLAG_W-1:0] f;
        f              = '0;
        f[FLG_ILLEGAL] = illegal;
        f[FLG_CARRY]   = carry;
        f[FLG_OVF]     = ovf;
        f[FLG_EQUAL]   = equal;
        f[FLG_ZERO]    = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational datapath for every single-cycle opcode and its flags.
// MUL is produced by the iterative multiplier in the top; here it yields zero.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [3:0]        op,
    output logic [WIDTH-1:0]  z,
    output logic [FLAG_W-1:0] flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SHW-1:0]   shamt_s;
    logic             carry_s;
    logic             ovf_s;
    logic             illegal_s;

    assign sum_s   = {1'b0, x} + {1'b0, y};
    assign diff_s  = {1'b0, x} - {1'b0, y};
    assign shamt_s = y[SHW-1:0];

    // Result mux; carry is NOT-borrow for SUB so it reads 1 when x >= y unsigned.
    always_comb begin
        z         = '0;
        carry_s   = 1'b0;
        ovf_s     = 1'b0;
        illegal_s = 1'b0;
        case (op)
            OP_ADD: begin
                z       = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (x[WIDTH-1] == y[WIDTH-1]) && (sum_s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                z       = diff_s[WIDTH-1:0];
                carry_s = ~diff_s[WIDTH];
                ovf_s   = (x[WIDTH-1] != y[WIDTH-1]) && (diff_s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NOR:  z = ~(x | y);
            OP_SLT:  z = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: z = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_SLL:  z = x << shamt_s;
            OP_SRL:  z = x >> shamt_s;
            OP_SRA:  z = $signed(x) >>> shamt_s;
            OP_MUL:  z = '0;
            default: illegal_s = 1'b1;
        endcase
    end

    assign flags = packFlags(illegal_s, carry_s, ovf_s, (x == y), (z == '0));

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register in one edge, MUL runs a WIDTH-step
// shift-add loop. Output register holds steady under backpressure.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic              okClk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_y,
    input  logic [3:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_z,
    output logic [TAG_W-1:0]  out_tag,
    output logic [FLAG_W-1:0] out_flags,
    output logic              busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e              state_r, nextState_s;
    logic [2*WIDTH-1:0]  mcand_r, acc_r, accNext_s;
    logic [WIDTH-1:0]    mplier_r;
    logic [CNT_W-1:0]    count_r;
    logic [TAG_W-1:0]    mulTag_r;
    logic                mulEqual_r;
    logic [WIDTH-1:0]    combZ_s;
    logic [FLAG_W-1:0]   combFlags_s;
    logic                inReady_s, accept_s, isMul_s, mulDone_s;
    logic                outValid_r;
    logic [WIDTH-1:0]    outZ_r;
    logic [TAG_W-1:0]    outTag_r;
    logic [FLAG_W-1:0]   outFlags_r;

    alu_seq_comb #(.WIDTH(WIDTH)) uComb (
        .x     (in_x),
        .y     (in_y),
        .op    (in_op),
        .z     (combZ_s),
        .flags (combFlags_s)
    );

    assign inReady_s = (state_r == IDLE) && (!outValid_r || out_ready);
    assign accept_s  = in_valid && inReady_s;
    assign isMul_s   = (in_op == OP_MUL);
    assign mulDone_s = (state_r == MUL_RUN) && (count_r == CNT_W'(WIDTH - 1));
    assign accNext_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    assign in_ready  = inReady_s;
    assign out_valid = outValid_r;
    assign out_z     = outZ_r;
    assign out_tag   = outTag_r;
    assign out_flags = outFlags_r;
    assign busy      = (state_r == MUL_RUN);

    // State register.
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; MUL_RUN always finishes since a free output slot was required to enter.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && isMul_s) nextState_s = MUL_RUN;
                else                     nextState_s = IDLE;
            end
            MUL_RUN: begin
                if (mulDone_s) nextState_s = IDLE;
                else           nextState_s = MUL_RUN;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Shift-add multiplier: latch operands on accept, one partial product per edge.
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r    <= '0;
            mplier_r   <= '0;
            acc_r      <= '0;
            count_r    <= '0;
            mulTag_r   <= '0;
            mulEqual_r <= 1'b0;
        end else if (state_r == IDLE) begin
            if (accept_s && isMul_s) begin
                mcand_r    <= {{WIDTH{1'b0}}, in_x};
                mplier_r   <= in_y;
                acc_r      <= '0;
                count_r    <= '0;
                mulTag_r   <= in_tag;
                mulEqual_r <= (in_x == in_y);
            end else begin
                count_r <= count_r;
            end
        end else begin
            acc_r    <= accNext_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r + CNT_W'(1);
        end
    end

    // Output register: a new result wins over a completing transfer on the same edge.
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_r <= 1'b0;
            outZ_r     <= '0;
            outTag_r   <= '0;
            outFlags_r <= '0;
        end else if (accept_s && !isMul_s) begin
            outValid_r <= 1'b1;
            outZ_r     <= combZ_s;
            outTag_r   <= in_tag;
            outFlags_r <= combFlags_s;
        end else if (mulDone_s) begin
            outValid_r <= 1'b1;
            outZ_r     <= accNext_s[WIDTH-1:0];
            outTag_r   <= mulTag_r;
            outFlags_r <= packFlags(1'b0, 1'b0, |accNext_s[2*WIDTH-1:WIDTH], mulEqual_r,
                                    (accNext_s[WIDTH-1:0] == '0));
        end else if (outValid_r && out_ready) begin
            outValid_r <= 1'b0;
        end else begin
            outValid_r <= outValid_r;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results come from an independent model
// and are queued on accept, then popped and compared when the output transfers.
module tb_alu_seq;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
        logic [4:0]  flags;
    } exp_t;

    logic        okClk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = 32'd0;
    logic [31:0] in_y = 32'd0;
    logic [3:0]  in_op = 4'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_z;
    logic [3:0]  out_tag;
    logic [4:0]  out_flags;
    logic        busy;

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    exp_t expQ[$];
    int   popCyc[$];

    alu_seq #(.WIDTH(32), .TAG_W(4)) dut (
        .okClk(okClk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_tag(out_tag), .out_flags(out_flags), .busy(busy)
    );

    always #5 okClk = ~okClk;

    always @(posedge okClk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [3:0] op, input logic [3:0] tag);
        exp_t   e;
        longint s;
        logic [63:0] p;
        logic [32:0] w;
        logic c, o, il;
        c = 1'b0; o = 1'b0; il = 1'b0;
        e.z = 32'd0;
        case (op)
            4'h0: begin
                w = {1'b0, x} + {1'b0, y}; e.z = w[31:0]; c = w[32];
                s = longint'($signed(x)) + longint'($signed(y));
                o = (s != longint'($signed(s[31:0])));
            end
            4'h1: begin
                e.z = x - y; c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                o = (s != longint'($signed(s[31:0])));
            end
            4'h2: e.z = x & y;
            4'h3: e.z = x | y;
            4'h4: e.z = x ^ y;
            4'h5: e.z = ~(x | y);
            4'h6: e.z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'h7: e.z = (x < y) ? 32'd1 : 32'd0;
            4'h8: e.z = x << y[4:0];
            4'h9: e.z = x >> y[4:0];
            4'hA: e.z = $signed(x) >>> y[4:0];
            4'hB: begin
                p = {32'd0, x} * {32'd0, y}; e.z = p[31:0]; o = (p[63:32] != 32'd0);
            end
            default: il = 1'b1;
        endcase
        e.tag   = tag;
        e.flags = {il, c, o, (x == y), (e.z == 32'd0)};
        return e;
    endfunction

    // Output monitor: every output transfer must match the oldest queued expectation.
    always @(negedge okClk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                chk("spurious_result", 64'(out_valid), 64'd0);
            end else begin
                e = expQ.pop_front();
                chk("out_z", 64'(out_z), 64'(e.z));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_flags", 64'(out_flags), 64'(e.flags));
                popCyc.push_back(cycle);
            end
        end
    end

    task automatic sendOp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        @(posedge okClk); #1;
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge okClk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        if (ok) expQ.push_back(model(x, y, op, tag));
    endtask

    task automatic idleIn();
        @(posedge okClk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge okClk);
        chk("drain_timeout", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge okClk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_z", 64'(out_z), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;
        @(negedge okClk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // ADD overflow, latency one cycle
        sendOp(4'h0, 32'h7FFF_FFFF, 32'd1, 4'd3);
        idleIn();
        @(negedge okClk);
        chk("add_latency", 64'(out_valid), 64'd1);
        chk("add_z", 64'(out_z), 64'h8000_0000);
        chk("add_flags", 64'(out_flags), 64'b00100);
        waitDrain();

        // Back-to-back throughput
        popCyc.delete();
        sendOp(4'h1, 32'd5, 32'd5, 4'd1);
        sendOp(4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd2);
        sendOp(4'h4, 32'hAAAA_5555, 32'hFFFF_0000, 4'd4);
        sendOp(4'h7, 32'd3, 32'hFFFF_FFFF, 4'd5);
        idleIn();
        waitDrain();
        chk("b2b_count", 64'(popCyc.size()), 64'd4);
        if (popCyc.size() == 4)
            for (int k = 1; k < 4; k++)
                chk("b2b_consecutive", 64'(popCyc[k] - popCyc[0]), 64'(k));

        // MUL with high-half overflow: exactly 32 cycles, busy throughout
        sendOp(4'hB, 32'h0001_0000, 32'h0001_0000, 4'd6);
        idleIn();
        for (int k = 0; k < 32; k++) begin
            @(negedge okClk);
            chk("mul_busy", 64'(busy), 64'd1);
            chk("mul_in_ready", 64'(in_ready), 64'd0);
            chk("mul_early_valid", 64'(out_valid), 64'd0);
        end
        @(negedge okClk);
        chk("mul_latency", 64'(out_valid), 64'd1);
        chk("mul_z", 64'(out_z), 64'd0);
        chk("mul_flags", 64'(out_flags), 64'b00111);
        waitDrain();
        sendOp(4'hB, 32'd7, 32'd6, 4'd7);
        idleIn();
        waitDrain();

        // Backpressure on SRA, input re-admitted on the releasing edge
        out_ready = 1'b0;
        sendOp(4'hA, 32'h8000_0000, 32'd4, 4'd8);
        @(posedge okClk); #1;
        in_op = 4'h0; in_x = 32'd10; in_y = 32'd20; in_tag = 4'd9;
        for (int k = 0; k < 10; k++) begin
            @(negedge okClk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_z_stable", 64'(out_z), 64'hF800_0000);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge okClk); #1;
        out_ready = 1'b1;
        @(negedge okClk);
        chk("bp_readmit", 64'(in_ready), 64'd1);
        expQ.push_back(model(32'd10, 32'd20, 4'h0, 4'd9));
        idleIn();
        @(negedge okClk);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        waitDrain();

        // Illegal opcode then a legal op clears the flag; shift-by-zero
        sendOp(4'hD, 32'd1, 32'd2, 4'd10);
        idleIn();
        @(negedge okClk);
        chk("illegal_flags", 64'(out_flags), 64'b10001);
        waitDrain();
        sendOp(4'h3, 32'd1, 32'd2, 4'd11);
        sendOp(4'h8, 32'h1234_5678, 32'hFFFF_FFE0, 4'd12);
        sendOp(4'h1, 32'h8000_0000, 32'd1, 4'd13);
        idleIn();
        waitDrain();

        // Mixed pseudo-random ops
        for (int k = 0; k < 16; k++)
            sendOp(4'($urandom_range(15, 0)), $urandom, $urandom, 4'(k));
        idleIn();
        waitDrain();

        // Reset during MUL discards the pending result
        sendOp(4'hB, 32'd3, 32'd5, 4'd14);
        idleIn();
        repeat (10) @(negedge okClk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_out_z", 64'(out_z), 64'd0);
        expQ.delete();
        repeat (2) @(negedge okClk);
        rst_n = 1'b1;
        @(negedge okClk);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge okClk);
            chk("mrst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 32-bit ALU, behind the same host wire/trigger endpoints.
- Accepts one operation per transaction on a valid/ready input channel and returns a registered result plus flags on a valid/ready output channel.
- Single-cycle ops have a fixed one-cycle latency; MUL is an iterative shift-add multiplier taking WIDTH cycles.
- A tag passes through so the host can match results to requests.

Parameters:
- WIDTH, 32, operand/result width in bits; must be 8 or greater.
- TAG_W, 4, width of the request tag returned with the result.

Ports:
- okClk  in  1  sole clock; all logic is synchronous to its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- in_op  in  4  opcode (see Behaviour).
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_z  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the request that produced out_z.
- out_flags  out  5  {illegal, carry, overflow, equal, zero}.
- busy  out  1  high while the multiplier is in MUL_RUN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; out_valid=0; out_z=0; out_tag=0; out_flags=0; busy=0; in_ready=1 after release.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU (result is 0 or 1).
  - 8 SLL, 9 SRL, A SRA: shift amount is in_y[$clog2(WIDTH)-1:0]; upper bits are ignored.
  - B MUL: low WIDTH bits of the unsigned product.
  - C-F illegal.
- Flags, all registered with the result:
  - zero = (out_z==0).
  - equal = (x==y), valid for every op.
  - overflow: signed overflow for ADD/SUB; high half of the 2*WIDTH product nonzero for MUL; 0 otherwise.
  - carry: carry-out for ADD; NOT borrow for SUB (1 when x>=y unsigned); 0 otherwise.
  - illegal: 1 for opcodes C-F, with out_z=0 and all other flags computed normally (zero=1).
- Handshakes:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A result being consumed this cycle frees the slot, so back-to-back throughput is one op per cycle for non-MUL ops.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_z, out_tag and out_flags hold stable.
  - out_valid falls only on a transfer edge with no new result written on that edge.
- State machine:
  - IDLE:
    - Non-MUL accept: result, tag and flags are registered on the same edge; out_valid=1 the next cycle (latency 1).
    - MUL accept: latch multiplicand, multiplier, tag; clear the 2*WIDTH accumulator; count=0; go to MUL_RUN; busy=1.
  - MUL_RUN:
    - Each edge: if multiplier LSB is set, add the shifted multiplicand to the accumulator; shift; count++.
    - On the edge where count reaches WIDTH-1, write out_z/flags/tag, set out_valid, return to IDLE.
    - MUL latency is WIDTH cycles from the accept edge to out_valid.
    - in_ready=0 throughout.
- Boundary rules:
  - MUL never starts while an unconsumed result is held, because in_ready requires a free slot. MUL_RUN therefore completes unconditionally.
  - Reset mid-MUL aborts immediately; no result is produced.
  - Shift by 0 returns x unchanged.
  - SRA of a negative x fills with ones.
  - SUB of the most negative value minus 1 sets overflow=1.
  - in_valid without in_ready is ignored; operands need not be held, since the handshake completes only on in_ready.

Decomposition:
- Package alu_seq_pkg holds:
  - op_e enum (4-bit opcodes above);
  - state_e {IDLE, MUL_RUN};
  - flag bit-index constants FLG_ZERO=0, FLG_EQUAL=1, FLG_OVF=2, FLG_CARRY=3, FLG_ILLEGAL=4.
- Sub-module alu_seq_comb: purely combinational WIDTH-parametrised datapath for all single-cycle ops and their flags.
- The top holds the FSM, the multiplier and the output register.

Test Plan:
- Reset, then ADD x=32'h7FFF_FFFF y=1 tag=3 -> one cycle later out_z=32'h8000_0000, overflow=1, carry=0, zero=0, out_tag=3.
- SUB x=5 y=5 -> out_z=0, zero=1, equal=1, carry=1. Back-to-back with out_ready=1 constantly: 4 ops yield 4 results on 4 consecutive cycles.
- MUL x=32'h0001_0000 y=32'h0001_0000 -> after exactly 32 cycles out_z=0 and overflow=1; busy=1 and in_ready=0 during those cycles. A second MUL, 7*6, gives out_z=42 with overflow=0.
- Backpressure: hold out_ready=0 after SRA x=32'h8000_0000 y=4 -> out_z=32'hF800_0000 stays stable and in_ready=0 for 10 cycles. Releasing out_ready completes the transfer and re-admits input on the same edge.
- Opcode 4'hD x=1 y=2 -> out_z=0, illegal=1, zero=1; the next legal op clears illegal.
- Assert rst_n=0 mid-MUL (cycle 10) -> out_valid=0, busy=0, in_ready=1 after release, and no stale result ever appears.
